hazard_controller: RTL
======================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of MEMEX wait cycles before abort (range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have ports rs1_ID and rs2_ID, input, 4 bits each, plus rs1_used_ID and rs2_used_ID, input, 1 bit each: the source registers of the instruction in ID.
REQ-005 The block SHALL have ports rs1_EX and rs2_EX, input, 4 bits each: the source registers of the instruction in EX.
REQ-006 The block SHALL have ports rd_EX, input, 4 bits; regfile_we_EX, input, 1 bit; and mem_read_EX, input, 1 bit: the destination, write enable and load flag of the instruction in EX.
REQ-007 The block SHALL have ports rd_MEMEX, input, 4 bits, and regfile_we_MEMEX, input, 1 bit; and rd_WB, input, 4 bits, and regfile_we_WB, input, 1 bit.
REQ-008 The block SHALL have ports mem_req_MEMEX, input, 1 bit (MEMEX issues a memory access), and mem_ack, input, 1 bit (memory completes this cycle).
REQ-009 The block SHALL have port branch_taken_EX, input, 1 bit: a taken branch or jump resolved in EX.
REQ-010 The block SHALL have outputs stall_IF, stall_ID, stall_EX and stall_MEMEX, 1 bit each: per-stage hold of the pipeline registers.
REQ-011 The block SHALL have outputs invalid_ID, invalid_EX and invalid_MEMEX, 1 bit each: inject a bubble into the named stage.
REQ-012 The block SHALL have outputs fwd_rs1_sel and fwd_rs2_sel, 2 bits each, encoded 00 regfile, 01 MEMEX result, 10 WB result.
REQ-013 The block SHALL have output mem_timeout, 1 bit, a one-cycle abort pulse; and output stall_count, 16 bits, the saturating count of stalled cycles.

Function
REQ-014 Register x0 (index 0) SHALL never match in any hazard or forwarding comparison.
REQ-015 The memory FSM SHALL have states MEM_IDLE and MEM_WAIT.
REQ-016 In MEM_IDLE, if mem_req_MEMEX=1 and mem_ack=0, the FSM SHALL assert all four stall outputs in that same cycle and enter MEM_WAIT.
REQ-017 In MEM_WAIT, the FSM SHALL increment an 8-bit wait counter each cycle and keep all stalls asserted.
REQ-018 In MEM_WAIT, mem_ack=1 SHALL deassert all stalls combinationally in that cycle and return the FSM to MEM_IDLE with the counter cleared.
REQ-019 When the wait counter equals MEM_TIMEOUT-1 with mem_ack=0, the block SHALL pulse mem_timeout and assert invalid_MEMEX for that cycle, release all stalls, and return to MEM_IDLE.
REQ-020 If mem_ack and the timeout coincide, mem_ack SHALL win and no abort SHALL occur.
REQ-021 A load-use hazard SHALL be detected when mem_read_EX=1, regfile_we_EX=1 and rd_EX equals a used ID source register.
REQ-022 On a load-use hazard the block SHALL assert stall_IF, stall_ID and invalid_EX for exactly one cycle.
REQ-023 branch_taken_EX=1 SHALL assert invalid_ID and invalid_EX for one cycle and suppress any load-use stall in that cycle.
REQ-024 The priority order SHALL be: memory stall > timeout abort > branch flush > load-use stall; a memory stall SHALL hold a pending branch flush until release.
REQ-025 Forwarding SHALL select MEMEX when regfile_we_MEMEX=1 and rd_MEMEX matches, else WB when regfile_we_WB=1 and rd_WB matches, else regfile.
REQ-026 stall_count SHALL increment on every cycle in which stall_IF=1 and saturate at 0xFFFF.

Reset
REQ-027 rst_n=0 SHALL immediately force the FSM to MEM_IDLE, the wait counter and stall_count to 0, and mem_timeout to 0.
REQ-028 While rst_n=0, all stall outputs SHALL read 0 and all invalid outputs SHALL read 1.
REQ-029 A reset asserted during MEM_WAIT SHALL abandon the access without pulsing mem_timeout.

Configuration
REQ-030 With macro HAZARD_FORWARDING_EN defined, REQ-025 forwarding SHALL be active.
REQ-031 With HAZARD_FORWARDING_EN undefined, both fwd selects SHALL be tied to 00.
REQ-032 With HAZARD_FORWARDING_EN undefined, any used ID source matching an enabled rd in EX, MEMEX or WB SHALL assert stall_IF, stall_ID and invalid_EX until no match remains.

Verification
REQ-033 A bench SHALL drive a load with rd_EX=5 and rs1_ID=5 used and check exactly one cycle of stall_IF=stall_ID=invalid_EX=1.
REQ-034 A bench SHALL drive mem_req_MEMEX=1 with mem_ack after 3 cycles and check stalls high for 3 cycles, low in the ack cycle, and stall_count=3.
REQ-035 A bench SHALL hold mem_req_MEMEX=1 with mem_ack=0 at MEM_TIMEOUT=4 and check a mem_timeout and invalid_MEMEX pulse in cycle 4 with stalls released.
REQ-036 A bench SHALL drive rd_MEMEX=3 and rd_WB=3, both enabled, with rs2_EX=3 and check fwd_rs2_sel=01; with rd_MEMEX=0 it SHALL check 10.
REQ-037 A bench SHALL assert branch_taken_EX together with a load-use match and check invalid_ID=invalid_EX=1 and stall_IF=0.
REQ-038 A bench SHALL assert rst_n=0 in cycle 2 of MEM_WAIT and check stalls 0 immediately, no mem_timeout, and the FSM in MEM_IDLE.

Source files
------------

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Pipeline hazard unit. It covers four jobs:
//   * Stalls the whole pipe while a MEMEX memory access waits for its ack.
//   * Aborts that access after MEM_TIMEOUT wait cycles.
//   * Flushes ID/EX on a taken branch resolved in EX.
//   * Handles data hazards on the instruction in ID. With forwarding enabled
//     only load-use stalls. Without it, a full interlock is used.
//
// Configuration macro: HAZARD_FORWARDING_EN
//   defined   -> EX operands are forwarded from MEMEX/WB. Only load-use
//                hazards stall.
//   undefined -> fwd selects are tied to 00. Any ID source that matches an
//                enabled rd in EX, MEMEX or WB stalls until the match clears.
//
// Memory handshake:
//   * mem_req_MEMEX is high while MEMEX owns a memory access.
//   * mem_ack is high in the cycle the access completes.
//   * If req is high and ack is low, the pipe is frozen that same cycle.
//     It stays frozen until ack or timeout.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   rs1/rs2_ID, rs1/rs2_used_ID      sources of the instruction in ID
//   rs1/rs2_EX                       sources of the instruction in EX
//   rd_EX, regfile_we_EX,            destination, write enable and load flag
//   mem_read_EX                        of the instruction in EX
//   rd/regfile_we_MEMEX, rd/regfile_we_WB   later-stage writers
//   mem_req_MEMEX, mem_ack           memory handshake
//   branch_taken_EX                  taken branch/jump in EX
//   stall_IF/ID/EX/MEMEX             per-stage pipeline register hold
//   invalid_ID/EX/MEMEX              bubble injection per stage
//   fwd_rs1_sel, fwd_rs2_sel         00 regfile, 01 MEMEX, 10 WB
//   mem_timeout                      one-cycle abort pulse
//   stall_count                      saturating count of stall_IF cycles
//   mem_state_dbg                    memory FSM state (1 = MEM_WAIT)
// -----------------------------------------------------------------------------
module hazard_controller #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  rs1_ID,
    input  logic [3:0]  rs2_ID,
    input  logic        rs1_used_ID,
    input  logic        rs2_used_ID,
    input  logic [3:0]  rs1_EX,
    input  logic [3:0]  rs2_EX,
    input  logic [3:0]  rd_EX,
    input  logic        regfile_we_EX,
    input  logic        mem_read_EX,
    input  logic [3:0]  rd_MEMEX,
    input  logic        regfile_we_MEMEX,
    input  logic [3:0]  rd_WB,
    input  logic        regfile_we_WB,
    input  logic        mem_req_MEMEX,
    input  logic        mem_ack,
    input  logic        branch_taken_EX,
    output logic        stall_IF,
    output logic        stall_ID,
    output logic        stall_EX,
    output logic        stall_MEMEX,
    output logic        invalid_ID,
    output logic        invalid_EX,
    output logic        invalid_MEMEX,
    output logic [1:0]  fwd_rs1_sel,
    output logic [1:0]  fwd_rs2_sel,
    output logic        mem_timeout,
    output logic [15:0] stall_count,
    output logic        mem_state_dbg
);

    typedef enum logic {MEM_IDLE = 1'b0, MEM_WAIT = 1'b1} mem_state_t;

    mem_state_t  state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        branch_pend_q, branch_pend_d;

    logic mem_stall, timeout_hit, flush_req, flush;
    logic load_use, data_hazard, dh_stall;

    // x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [3:0] a, input logic [3:0] b);
        return (a != 4'd0) && (a == b);
    endfunction

    function automatic logic id_hit(input logic [3:0] rd);
        return (rs1_used_ID && reg_match(rs1_ID, rd)) ||
               (rs2_used_ID && reg_match(rs2_ID, rd));
    endfunction

`ifdef HAZARD_FORWARDING_EN
    function automatic logic [1:0] fwd_sel(input logic [3:0] rs);
        if (regfile_we_MEMEX && reg_match(rs, rd_MEMEX)) return 2'b01;
        if (regfile_we_WB && reg_match(rs, rd_WB))       return 2'b10;
        return 2'b00;
    endfunction
`endif

    // Memory FSM, timeout and branch-hold bookkeeping
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_stall     = 1'b0;
        timeout_hit   = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                wait_cnt_d = 8'd0;
                if (mem_req_MEMEX && !mem_ack) begin
                    mem_stall  = 1'b1;
                    state_d    = MEM_WAIT;
                    // The request cycle counts as the first wait cycle.
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    // An ack always beats a coincident timeout.
                    state_d    = MEM_IDLE;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == 8'(MEM_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = MEM_IDLE;
                    wait_cnt_d  = 8'd0;
                end else begin
                    mem_stall  = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = MEM_IDLE;
                wait_cnt_d = 8'd0;
            end
        endcase

        // A branch that resolves while the pipe is frozen is remembered.
        // The flush is then applied in the release cycle.
        flush_req     = branch_taken_EX || branch_pend_q;
        flush         = flush_req && !mem_stall;
        branch_pend_d = mem_stall ? flush_req : 1'b0;
    end

    // Data hazards on the instruction in ID
    always_comb begin
        load_use = mem_read_EX && regfile_we_EX && id_hit(rd_EX);
`ifdef HAZARD_FORWARDING_EN
        data_hazard = load_use;
        fwd_rs1_sel = fwd_sel(rs1_EX);
        fwd_rs2_sel = fwd_sel(rs2_EX);
`else
        data_hazard = load_use ||
                      (regfile_we_EX    && id_hit(rd_EX))    ||
                      (regfile_we_MEMEX && id_hit(rd_MEMEX)) ||
                      (regfile_we_WB    && id_hit(rd_WB));
        fwd_rs1_sel = 2'b00;
        fwd_rs2_sel = 2'b00;
`endif
        // Priority: memory stall > timeout abort > branch flush > data hazard.
        dh_stall = data_hazard && !mem_stall && !timeout_hit && !flush_req;
    end

`ifndef HAZARD_FORWARDING_EN
    logic unused_ex_srcs;
    assign unused_ex_srcs = ^{rs1_EX, rs2_EX};
`endif

    // Outputs
    // While in reset, nothing holds and every stage reads as a bubble.
    always_comb begin
        stall_IF      = 1'b0;
        stall_ID      = 1'b0;
        stall_EX      = 1'b0;
        stall_MEMEX   = 1'b0;
        invalid_ID    = 1'b1;
        invalid_EX    = 1'b1;
        invalid_MEMEX = 1'b1;
        mem_timeout   = 1'b0;
        if (rst_n) begin
            stall_IF      = mem_stall || dh_stall;
            stall_ID      = mem_stall || dh_stall;
            stall_EX      = mem_stall;
            stall_MEMEX   = mem_stall;
            invalid_ID    = flush;
            invalid_EX    = flush || dh_stall;
            invalid_MEMEX = timeout_hit;
            mem_timeout   = timeout_hit;
        end
        stall_count_d = (stall_IF && stall_count_q != 16'hFFFF) ?
                        stall_count_q + 16'd1 : stall_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= MEM_IDLE;
            wait_cnt_q    <= 8'd0;
            stall_count_q <= 16'd0;
            branch_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
            branch_pend_q <= branch_pend_d;
        end
    end

    assign stall_count   = stall_count_q;
    assign mem_state_dbg = (state_q == MEM_WAIT);

endmodule
